// File: rtl/serializer_pkg.sv
// Shared types and slice helper for the serializer datapath and its future deserializer twin.
package serializer_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    // Widest word the shared slice helper supports.
    localparam int MAX_W = 256;

    // Returns beat k of a data_w-bit word in the low lanes bits; callers truncate to their width.
    function automatic logic [MAX_W-1:0] beat_slice(
        input logic [MAX_W-1:0] word,
        input int               k,
        input bit               msb_first,
        input int               data_w,
        input int               lanes
    );
        int shift;
        shift = msb_first ? data_w - (k + 1) * lanes : k * lanes;
        return word >> shift;
    endfunction

endpackage

// File: rtl/ser_hold_buffer.sv
// One-entry word register with load/unload and a full flag.
module ser_hold_buffer
    import serializer_pkg::*;
#(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         full
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

    // NOTE: the payload register is not reset; it is only read while full=1, so resetting it buys nothing.
    always_ff @(posedge clk) begin
        if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/lane_serializer.sv
// Parallel-to-serial converter: DATA_W-bit words in over valid/ready, LANES bits out per cycle.
module lane_serializer
    import serializer_pkg::*;
#(
    parameter int                DATA_W       = 20,
    parameter int                LANES        = 4,
    parameter bit                MSB_FIRST    = 1'b1,
    parameter logic [LANES-1:0]  IDLE_PATTERN = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [LANES-1:0]  data_o,
    output logic              valid_o,
    output logic              sof_o
);

    localparam int BEATS = DATA_W / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    if (LANES < 1 || DATA_W % LANES != 0 || DATA_W > MAX_W) begin : g_param_check
        $fatal(1, "lane_serializer: DATA_W must be a multiple of LANES, LANES >= 1");
    end

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  shifter;
    logic [DATA_W-1:0]  hold_q;
    logic               hold_full;
    logic               xfer;
    logic               boundary;
    logic               start_new;
    logic               hold_load;
    logic               hold_unload;
    logic [DATA_W-1:0]  new_word;

    function automatic logic [LANES-1:0] slice_of(input logic [DATA_W-1:0] w, input int k);
        return LANES'(beat_slice(MAX_W'(w), k, MSB_FIRST, DATA_W, LANES));
    endfunction

    // In SHIFT, cnt is the next beat to emit; cnt=0 means the final slice is on data_o.
    assign ready_o     = reset && !hold_full;
    assign xfer        = valid_i && ready_o;
    assign boundary    = (state == SHIFT) && (cnt == '0);
    assign start_new   = ((state == IDLE) && xfer) || (boundary && (hold_full || xfer));
    assign new_word    = (boundary && hold_full) ? hold_q : data_i;
    assign hold_load   = xfer && (state == SHIFT) && !boundary;
    assign hold_unload = boundary && hold_full;

    ser_hold_buffer #(
        .W(DATA_W)
    ) u_hold (
        .clk    (clk),
        .reset  (reset),
        .load   (hold_load),
        .unload (hold_unload),
        .d      (data_i),
        .q      (hold_q),
        .full   (hold_full)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            data_o  <= IDLE_PATTERN;
            valid_o <= 1'b0;
            sof_o   <= 1'b0;
        end else if (start_new) begin
            data_o  <= slice_of(new_word, 0);
            valid_o <= 1'b1;
            sof_o   <= 1'b1;
            cnt     <= CNT_W'(1);
            state   <= (BEATS > 1) ? SHIFT : IDLE;
        end else if ((state == SHIFT) && !boundary) begin
            data_o  <= slice_of(shifter, int'(cnt));
            valid_o <= 1'b1;
            sof_o   <= 1'b0;
            cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end else begin
            data_o  <= IDLE_PATTERN;
            valid_o <= 1'b0;
            sof_o   <= 1'b0;
            state   <= IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (start_new) begin
            shifter <= new_word;
        end
    end

endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: four configurations checked against a queue-based beat model plus literal vectors.
module tb_lane_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   cmp_en = 1'b0;

    logic        v0, v1, v2, v3;
    logic [19:0] d0, d1;
    logic [3:0]  d2;
    logic [7:0]  d3;
    logic        r0, r1, r2, r3;
    logic [3:0]  q0, q1;
    logic        q2;
    logic [7:0]  q3;
    logic        ov0, ov1, ov2, ov3;
    logic        s0, s1, s2, s3;

    lane_serializer #(.DATA_W(20), .LANES(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(rst), .data_i(d0), .valid_i(v0), .ready_o(r0),
        .data_o(q0), .valid_o(ov0), .sof_o(s0));
    lane_serializer #(.DATA_W(20), .LANES(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(rst), .data_i(d1), .valid_i(v1), .ready_o(r1),
        .data_o(q1), .valid_o(ov1), .sof_o(s1));
    lane_serializer #(.DATA_W(4), .LANES(1), .MSB_FIRST(1'b1)) u_bit (
        .clk(clk), .reset(rst), .data_i(d2), .valid_i(v2), .ready_o(r2),
        .data_o(q2), .valid_o(ov2), .sof_o(s2));
    lane_serializer #(.DATA_W(8), .LANES(8), .MSB_FIRST(1'b1)) u_one (
        .clk(clk), .reset(rst), .data_i(d3), .valid_i(v3), .ready_o(r3),
        .data_o(q3), .valid_o(ov3), .sof_o(s3));

    int cfg_dw [4] = '{20, 20, 4, 8};
    int cfg_ln [4] = '{4, 4, 1, 8};
    bit cfg_msb[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_dout(input int k);
        case (k)
            0: return 32'(q0);
            1: return 32'(q1);
            2: return 32'(q2);
            default: return 32'(q3);
        endcase
    endfunction

    function automatic logic get_valid(input int k);
        case (k)
            0: return ov0;
            1: return ov1;
            2: return ov2;
            default: return ov3;
        endcase
    endfunction

    function automatic logic get_sof(input int k);
        case (k)
            0: return s0;
            1: return s1;
            2: return s2;
            default: return s3;
        endcase
    endfunction

    function automatic logic get_ready(input int k);
        case (k)
            0: return r0;
            1: return r1;
            2: return r2;
            default: return r3;
        endcase
    endfunction

    function automatic logic get_vin(input int k);
        case (k)
            0: return v0;
            1: return v1;
            2: return v2;
            default: return v3;
        endcase
    endfunction

    function automatic logic [31:0] get_din(input int k);
        case (k)
            0: return 32'(d0);
            1: return 32'(d1);
            2: return 32'(d2);
            default: return 32'(d3);
        endcase
    endfunction

    task automatic drive(input int k, input logic v, input logic [31:0] w);
        case (k)
            0: begin v0 = v; d0 = w[19:0]; end
            1: begin v1 = v; d1 = w[19:0]; end
            2: begin v2 = v; d2 = w[3:0];  end
            default: begin v3 = v; d3 = w[7:0]; end
        endcase
    endtask

    // Model: a queue of pending beats per instance plus an optional waiting word.
    int unsigned mq[4][$];
    bit          held_v[4] = '{0, 0, 0, 0};
    logic [31:0] held_w[4];
    bit          e_valid[4] = '{0, 0, 0, 0};
    bit          e_sof[4]   = '{0, 0, 0, 0};
    logic [31:0] e_data[4]  = '{0, 0, 0, 0};

    function automatic void push_word(input int k, input logic [31:0] w);
        int beats;
        beats = cfg_dw[k] / cfg_ln[k];
        for (int b = 0; b < beats; b++) begin
            int          sh;
            logic [31:0] s;
            sh = cfg_msb[k] ? cfg_dw[k] - (b + 1) * cfg_ln[k] : b * cfg_ln[k];
            s  = (w >> sh) & ((32'd1 << cfg_ln[k]) - 32'd1);
            mq[k].push_back(s | ((b == 0) ? 32'h1_0000 : 32'h0));
        end
    endfunction

    function automatic void emit(input int k);
        int unsigned e;
        e = mq[k].pop_front();
        e_valid[k] = 1'b1;
        e_data[k]  = e & 32'hFFFF;
        e_sof[k]   = ((e >> 16) & 1) != 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                mq[k].delete();
                held_v[k]  = 1'b0;
                e_valid[k] = 1'b0;
                e_sof[k]   = 1'b0;
                e_data[k]  = '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                bit xfer;
                xfer = get_vin(k) && !held_v[k];
                if (mq[k].size() > 0) begin
                    emit(k);
                    if (xfer) begin
                        held_v[k] = 1'b1;
                        held_w[k] = get_din(k);
                    end
                end else if (held_v[k]) begin
                    push_word(k, held_w[k]);
                    held_v[k] = 1'b0;
                    emit(k);
                end else if (xfer) begin
                    push_word(k, get_din(k));
                    emit(k);
                end else begin
                    e_valid[k] = 1'b0;
                    e_sof[k]   = 1'b0;
                    e_data[k]  = '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("valid_o[%0d]", k), 32'(get_valid(k)), 32'(e_valid[k]));
                check($sformatf("data_o[%0d]", k),  get_dout(k), e_data[k]);
                check($sformatf("sof_o[%0d]", k),   32'(get_sof(k)), 32'(e_sof[k]));
                check($sformatf("ready_o[%0d]", k), 32'(get_ready(k)), 32'(rst && !held_v[k]));
            end
        end
    end

    task automatic single_word(input int k, input logic [31:0] w, input int exp[5], input int nb);
        drive(k, 1'b1, w);
        @(posedge clk); #2;
        drive(k, 1'b0, '0);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            check($sformatf("lit_beat%0d[%0d]", i, k), get_dout(k), 32'(exp[i]));
            check($sformatf("lit_sof%0d[%0d]", i, k), 32'(get_sof(k)), (i == 0) ? 32'd1 : 32'd0);
            @(posedge clk); #2;
        end
        @(negedge clk);
        check($sformatf("lit_idle_valid[%0d]", k), 32'(get_valid(k)), 32'd0);
        check($sformatf("lit_idle_data[%0d]", k), get_dout(k), 32'd0);
        @(posedge clk); #2;
    endtask

    task automatic stream(input int k, input logic [31:0] w[8], input int n, output int acc[8]);
        int idx;
        int cyc;
        logic r;
        idx = 0;
        cyc = 0;
        acc = '{-1, -1, -1, -1, -1, -1, -1, -1};
        drive(k, 1'b1, w[0]);
        while (idx < n && cyc < 200) begin
            @(negedge clk);
            r = get_ready(k);
            @(posedge clk); #2;
            if (r) begin
                acc[idx] = cyc;
                idx++;
                drive(k, idx < n, (idx < n) ? w[idx] : 32'h0);
            end
            cyc++;
        end
        drive(k, 1'b0, '0);
        check($sformatf("stream_accepted[%0d]", k), 32'(idx), 32'(n));
    endtask

    initial begin
        logic [31:0] words[8];
        int          acc[8];

        rst = 1'b0;
        for (int k = 0; k < 4; k++) drive(k, 1'b0, '0);
        cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        @(negedge clk);
        check("reset_valid", 32'(ov0), 32'd0);
        check("reset_ready", 32'(r0), 32'd0);
        check("reset_data", 32'(q0), 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;

        single_word(0, 32'hABCDE, '{10, 11, 12, 13, 14}, 5);
        single_word(1, 32'hABCDE, '{14, 13, 12, 11, 10}, 5);

        words = '{32'h12345, 32'h6789A, 32'hFEDCB, 0, 0, 0, 0, 0};
        stream(0, words, 3, acc);
        check("three_xfer0", 32'(acc[0]), 32'd0);
        check("three_xfer1", 32'(acc[1]), 32'd1);
        check("three_xfer2", 32'(acc[2]), 32'd6);
        repeat (20) @(posedge clk);
        #2;

        drive(0, 1'b1, 32'hABCDE);
        @(posedge clk); #2;
        drive(0, 1'b1, 32'h11111);
        @(posedge clk); #2;
        drive(0, 1'b0, '0);
        @(negedge clk);
        check("hold_full_ready", 32'(r0), 32'd0);
        @(posedge clk); #2;
        check("mid_beat2", 32'(q0), 32'hC);
        rst = 1'b0;
        #1;
        check("async_valid", 32'(ov0), 32'd0);
        check("async_sof", 32'(s0), 32'd0);
        check("async_data", 32'(q0), 32'd0);
        check("async_ready", 32'(r0), 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        single_word(0, 32'h00001, '{0, 0, 0, 0, 1}, 5);

        words = '{32'hA, 32'h6, 0, 0, 0, 0, 0, 0};
        stream(2, words, 2, acc);
        check("bit_xfer1", 32'(acc[1]), 32'd1);
        repeat (12) @(posedge clk);
        #2;

        single_word(3, 32'h5A, '{90, 0, 0, 0, 0}, 1);
        words = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 0, 0};
        stream(3, words, 6, acc);
        for (int i = 0; i < 6; i++) check($sformatf("one_xfer%0d", i), 32'(acc[i]), 32'(i));
        repeat (5) @(posedge clk);
        #2;

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
